read_batch_loader: RTL and testbench
====================================

Name: read_batch_loader

Overview:
- Upstream feeder for the read-RAM stage that holds the batch of reads.
- Accepts a host cache-line stream over valid/ready: one header line, then exactly 4 lines per read (read bases part 1, read bases part 2, params, ik).
- Drives the read-RAM load interface: load_valid, load_data, batch_size. Waits for load_done and reports batch completion or error.
- Issues a one-cycle clear so the read-RAM's 2-bit line arbiter and position counter restart at 0 for each batch.

Parameters:
- CL, 512, cache-line width in bits.
- READ_NUM_WIDTH, 10, read index width.
- MAX_READ, 1024, maximum reads per batch.
- DONE_TIMEOUT, 255, cycles allowed in WAIT_DONE before an error is flagged.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a batch.
- host_valid  in  1  host line valid.
- host_data  in  CL  host cache line.
- host_ready  out  1  loader accepts a line this cycle.
- ram_clear  out  1  one-cycle pulse to reset the read-RAM load logic.
- load_valid  out  1  load_data valid to the read-RAM.
- load_data  out  CL  line to the read-RAM.
- batch_size  out  READ_NUM_WIDTH+1  read count from the header.
- load_done  in  1  read-RAM reports all reads stored.
- busy  out  1  batch in progress.
- done  out  1  batch loaded; level output.
- error  out  1  bad header or timeout; level output.

Behaviour:
- Reset (asynchronous, active-high) values:
  - All outputs 0; state IDLE; counters 0.
  - host_ready de-asserts immediately on reset, including mid-batch. Any partial batch is discarded.
- A transfer occurs on host_valid & host_ready at a rising edge of clk.
- States:
  - IDLE:
    - host_ready=0.
    - On start: ram_clear=1 for the next cycle; done and error clear to 0; go to HDR.
  - HDR:
    - host_ready=1. On transfer, capture N = host_data[READ_NUM_WIDTH:0].
    - If N==0 or N>MAX_READ: error=1, go to IDLE, batch_size unchanged.
    - Otherwise: batch_size<=N, line_cnt<=0, go to STREAM.
  - STREAM:
    - host_ready=1.
    - Each transfer: load_valid<=1 and load_data<=host_data in the following cycle (1-cycle latency, registered); line_cnt increments.
    - load_valid is 0 in any cycle after a non-transfer.
    - When the transfer with line_cnt==4*N-1 occurs, go to WAIT_DONE; host_ready is 0 from the next cycle.
  - WAIT_DONE:
    - host_ready=0; wait counter increments each cycle.
    - On load_done: done=1, go to IDLE.
    - If the counter reaches DONE_TIMEOUT with no load_done: error=1, go to IDLE.
- Counter widths:
  - line_cnt is 13 bits (max 4*1024-1 = 4095); compare against {N,2'b00}-1.
  - The wait counter is 8 bits and saturates.
- busy=1 in HDR, STREAM and WAIT_DONE.
- batch_size holds its value until the next valid header; it is not cleared by start.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle as the final load_done: done is set first; the start is ignored because the state is not yet IDLE.
  - load_done during HDR or STREAM: ignored.
  - host_valid while host_ready=0: no transfer, no state change.
- Line ordering within each read is the host's responsibility. The loader enforces only the total count of 4*N lines.
- Outputs done and error hold their value until the next start or reset.

Test Plan:
- Basic batch:
  - Stimulus: reset, start, header N=2, 8 back-to-back lines with data = line index, load_done asserted 1 cycle after the last load_valid.
  - Required: ram_clear pulses once; batch_size=2; load_valid high for 8 cycles carrying lines 0..7 with 1-cycle lag; done=1; busy=0.
- Bad header:
  - Stimulus: header N=0, then a separate batch with header N=1025.
  - Required: error=1 and state back in IDLE after each; no load_valid pulses; batch_size keeps its prior value.
- Throttled host:
  - Stimulus: N=1, host_valid toggling 1,0,1,0.
  - Required: exactly 4 load_valid pulses, each 1 cycle after its transfer; host_ready drops after the 4th transfer.
- Timeout:
  - Stimulus: N=1, 4 lines sent, load_done never asserted.
  - Required: error=1 exactly DONE_TIMEOUT cycles after entering WAIT_DONE; done=0.
- Reset mid-STREAM:
  - Stimulus: N=3; reset asserted asynchronously after 5 lines.
  - Required: host_ready, load_valid and busy go to 0 without waiting for a clock edge; a new start plus full batch N=1 completes with done=1.
- Start while busy:
  - Stimulus: start pulses during HDR and during STREAM; N=1024 full batch.
  - Required: extra starts ignored; 4096 lines forwarded; done=1.

Source files
------------

// File: rtl/read_batch_loader.sv
// read_batch_loader: host cache-line stream to read-RAM loader.
// Takes one header line then 4 lines per read; waits for load_done.
module read_batch_loader #(
  parameter int CL             = 512,
  parameter int READ_NUM_WIDTH = 10,
  parameter int MAX_READ       = 1024,
  parameter int DONE_TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    host_valid,
  input  logic [CL-1:0]           host_data,
  output logic                    host_ready,
  output logic                    ram_clear,
  output logic                    load_valid,
  output logic [CL-1:0]           load_data,
  output logic [READ_NUM_WIDTH:0] batch_size,
  input  logic                    load_done,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int NW = READ_NUM_WIDTH + 1;
  localparam int LW = READ_NUM_WIDTH + 3;
  localparam int WW = 8;

  localparam logic [NW-1:0] MAX_N = NW'(MAX_READ);
  localparam logic [WW-1:0] TO    = WW'(DONE_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    STREAM,
    WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   line_cnt_q, line_cnt_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [NW-1:0]   batch_size_q, batch_size_d;
  logic [CL-1:0]   load_data_q, load_data_d;
  logic            load_valid_q, load_valid_d;
  logic            ram_clear_q, ram_clear_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            xfer;
  logic [NW-1:0]   hdr_n;
  logic            hdr_bad;
  logic [LW-1:0]   last_line;
  logic [WW-1:0]   wait_inc;

  assign xfer      = host_valid & host_ready;
  assign hdr_n     = host_data[READ_NUM_WIDTH:0];
  assign hdr_bad   = (hdr_n == '0) || (hdr_n > MAX_N);
  assign last_line = {batch_size_q, 2'b00} - LW'(1);
  assign wait_inc  = (wait_cnt_q == '1) ? wait_cnt_q
                                        : wait_cnt_q + WW'(1);

  // State and datapath registers; reset drops everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      line_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      batch_size_q <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      ram_clear_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_cnt_q   <= line_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      batch_size_q <= batch_size_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      ram_clear_q  <= ram_clear_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Next-state and next-register logic for the batch sequence.
  always_comb begin
    state_d      = state_q;
    line_cnt_d   = line_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    batch_size_d = batch_size_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    ram_clear_d  = 1'b0;
    done_d       = done_q;
    error_d      = error_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ram_clear_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          state_d     = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          if (hdr_bad) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            batch_size_d = hdr_n;
            line_cnt_d   = '0;
            state_d      = STREAM;
          end
        end
      end
      STREAM: begin
        if (xfer) begin
          load_valid_d = 1'b1;
          load_data_d  = host_data;
          line_cnt_d   = line_cnt_q + LW'(1);
          if (line_cnt_q == last_line) begin
            wait_cnt_d = '0;
            state_d    = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (load_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == TO) begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; ready and busy follow state so reset clears them at once.
  always_comb begin
    host_ready = (state_q == HDR) || (state_q == STREAM);
    busy       = (state_q != IDLE);
    ram_clear  = ram_clear_q;
    load_valid = load_valid_q;
    load_data  = load_data_q;
    batch_size = batch_size_q;
    done       = done_q;
    error      = error_q;
  end

endmodule

// File: tb/tb_read_batch_loader.sv
// tb_read_batch_loader: directed vector bench for read_batch_loader.
// Table rows plus hand sequences for throttling, timeout, reset, big batch.
module tb_read_batch_loader;

  localparam int CL = 512;
  localparam logic [31:0] L = 32'hC0DE_0000;

  logic            clk;
  logic            reset;
  logic            start;
  logic            host_valid;
  logic [CL-1:0]   host_data;
  logic            host_ready;
  logic            ram_clear;
  logic            load_valid;
  logic [CL-1:0]   load_data;
  logic [10:0]     batch_size;
  logic            load_done;
  logic            busy;
  logic            done;
  logic            error;

  int n_tests = 0;
  int n_fail  = 0;

  read_batch_loader #(
    .CL(CL),
    .READ_NUM_WIDTH(10),
    .MAX_READ(1024),
    .DONE_TIMEOUT(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .host_valid(host_valid),
    .host_data(host_data),
    .host_ready(host_ready),
    .ram_clear(ram_clear),
    .load_valid(load_valid),
    .load_data(load_data),
    .batch_size(batch_size),
    .load_done(load_done),
    .busy(busy),
    .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        hv;
    logic        ld;
    logic [31:0] d;
    logic        hr;
    logic        rc;
    logic        lv;
    logic [31:0] q;
    logic        bz;
    logic        dn;
    logic        er;
    logic [10:0] bs;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [CL-1:0] pat(input logic [31:0] x);
    return {16{x}};
  endfunction

  function automatic vec_t mk(
    input int st, input int hv, input int ld, input logic [31:0] d,
    input int hr, input int rc, input int lv, input logic [31:0] q,
    input int bz, input int dn, input int er, input int bs);
    vec_t v;
    v.st = (st != 0);
    v.hv = (hv != 0);
    v.ld = (ld != 0);
    v.d  = d;
    v.hr = (hr != 0);
    v.rc = (rc != 0);
    v.lv = (lv != 0);
    v.q  = q;
    v.bz = (bz != 0);
    v.dn = (dn != 0);
    v.er = (er != 0);
    v.bs = 11'(bs);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int st, input int hv, input int ld,
                       input logic [31:0] d);
    start      = (st != 0);
    host_valid = (hv != 0);
    load_done  = (ld != 0);
    host_data  = pat(d);
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    logic ok;
    drive(int'(v.st), int'(v.hv), int'(v.ld), v.d);
    ok = (host_ready === v.hr) && (ram_clear === v.rc) &&
         (load_valid === v.lv) && (load_data === pat(v.q)) &&
         (busy === v.bz) && (done === v.dn) &&
         (error === v.er) && (batch_size === v.bs);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL row%0d: got hr%b rc%b lv%b q%h bz%b dn%b er%b bs%0d expected hr%b rc%b lv%b q%h bz%b dn%b er%b bs%0d",
        idx, host_ready, ram_clear, load_valid, load_data[31:0], busy,
        done, error, batch_size, v.hr, v.rc, v.lv, v.q, v.bz, v.dn,
        v.er, v.bs);
    end
  endtask

  task automatic begin_batch(input logic [31:0] n);
    drive(1, 0, 0, 32'd0);
    drive(0, 1, 0, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    int first;
    int bad;
    int fwd;

    // Basic batch N=2, stray host_valid, start with final load_done.
    tbl.push_back(mk(1,0,0,0,        1,1,0,0,   1,0,0,0));
    tbl.push_back(mk(0,1,0,2,        1,0,0,0,   1,0,0,2));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0,1,0,L+i,    1,0,1,L+i, 1,0,0,2));
    tbl.push_back(mk(0,1,0,L+7,      0,0,1,L+7, 1,0,0,2));
    tbl.push_back(mk(0,1,0,32'hDEAD, 0,0,0,L+7, 1,0,0,2));
    tbl.push_back(mk(1,0,1,0,        0,0,0,L+7, 0,1,0,2));
    tbl.push_back(mk(0,1,0,5,        0,0,0,L+7, 0,1,0,2));
    // Bad headers N=0 and N=1025 keep batch_size.
    tbl.push_back(mk(1,0,0,0,        1,1,0,L+7, 1,0,0,2));
    tbl.push_back(mk(0,1,0,0,        0,0,0,L+7, 0,0,1,2));
    tbl.push_back(mk(0,0,0,0,        0,0,0,L+7, 0,0,1,2));
    tbl.push_back(mk(1,0,0,0,        1,1,0,L+7, 1,0,0,2));
    tbl.push_back(mk(0,1,0,1025,     0,0,0,L+7, 0,0,1,2));
    tbl.push_back(mk(0,1,1,3,        0,0,0,L+7, 0,0,1,2));

    reset      = 1'b1;
    start      = 1'b0;
    host_valid = 1'b0;
    load_done  = 1'b0;
    host_data  = '0;
    #3;
    chk("rst_ready", 64'(host_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_lv", 64'(load_valid), 64'(0));
    chk("rst_clear", 64'(ram_clear), 64'(0));
    chk("rst_flags", 64'({done, error}), 64'(0));
    chk("rst_bs", 64'(batch_size), 64'(0));
    #9;
    reset = 1'b0;

    foreach (tbl[i]) run_row(tbl[i], i);

    // Throttled host, N=1.
    begin_batch(1);
    chk("thr_hdr_bs", 64'(batch_size), 64'(1));
    pulses = 0;
    for (int s = 0; s < 8; s++) begin
      drive(0, (s % 2 == 0) ? 1 : 0, 0, L + s);
      if (load_valid) pulses++;
      chk("thr_lv", 64'(load_valid), 64'((s % 2 == 0) ? 1 : 0));
      if (s % 2 == 0)
        chk("thr_data", 64'(load_data === pat(L + s)), 64'(1));
      chk("thr_ready", 64'(host_ready), 64'((s < 6) ? 1 : 0));
    end
    chk("thr_pulses", 64'(pulses), 64'(4));
    drive(0, 0, 1, 32'd0);
    chk("thr_done", 64'({done, error, busy}), 64'(3'b100));

    // Timeout: load_done never arrives.
    begin_batch(1);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, L + i);
    chk("to_enter", 64'({busy, host_ready}), 64'(2'b10));
    first = 0;
    for (int k = 1; k <= 300 && first == 0; k++) begin
      drive(0, 0, 0, 32'd0);
      if (error) first = k;
    end
    chk("to_cycles", 64'(first), 64'(255));
    chk("to_flags", 64'({done, busy}), 64'(0));

    // Asynchronous reset mid-stream, then a clean N=1 batch.
    begin_batch(3);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, L + i);
    chk("rm_pre", 64'({busy, host_ready, load_valid}), 64'(3'b111));
    #3;
    reset = 1'b1;
    #1;
    chk("rm_ready", 64'(host_ready), 64'(0));
    chk("rm_lv", 64'(load_valid), 64'(0));
    chk("rm_busy", 64'(busy), 64'(0));
    chk("rm_bs", 64'(batch_size), 64'(0));
    #2;
    reset = 1'b0;
    begin_batch(1);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, L + i);
    drive(0, 0, 1, 32'd0);
    chk("rm_done", 64'({done, error, busy}), 64'(3'b100));
    chk("rm_bs2", 64'(batch_size), 64'(1));

    // Extra starts and early load_done during a full 1024-read batch.
    drive(1, 0, 0, 32'd0);
    chk("big_clear", 64'(ram_clear), 64'(1));
    drive(1, 0, 0, 32'd0);
    chk("big_hdr_start", 64'({ram_clear, busy, host_ready}), 64'(3'b011));
    drive(1, 1, 0, 32'd1024);
    chk("big_bs", 64'(batch_size), 64'(1024));
    bad = 0;
    fwd = 0;
    for (int i = 0; i < 4096; i++) begin
      drive((i == 100) ? 1 : 0, 1, (i == 200) ? 1 : 0, L + i);
      if (load_valid) fwd++;
      if (!load_valid || load_data !== pat(L + i)) bad++;
      if (ram_clear || done || error) bad++;
      if (host_ready !== ((i < 4095) ? 1'b1 : 1'b0)) bad++;
    end
    chk("big_stream_errs", 64'(bad), 64'(0));
    chk("big_forwarded", 64'(fwd), 64'(4096));
    drive(0, 0, 1, 32'd0);
    chk("big_done", 64'({done, error, busy}), 64'(3'b100));
    chk("big_bs_hold", 64'(batch_size), 64'(1024));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
